// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package timer_pkg;

    localparam int unsigned FIELD_W = 6;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned SEC_MAX = 59;

    typedef logic [FIELD_W-1:0] time_field_t;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } cd_state_t;

    // Increment that wraps to zero once the field has reached its ceiling.
    function automatic time_field_t wrap_inc(input time_field_t v, input time_field_t max_v);
        return (v >= max_v) ? '0 : v + FIELD_W'(1);
    endfunction

endpackage

// File: rtl/mmss_counter.sv
// MM:SS value register with setting increments (wrap, no carry) and countdown borrow.
module mmss_counter
    import timer_pkg::*;
#(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_zero,
    input  logic               inc_min,
    input  logic               inc_sec,
    input  logic               dec,
    output logic [FIELD_W-1:0] mm,
    output logic [FIELD_W-1:0] ss,
    output logic               is_zero,
    output logic               is_one
);

    time_field_t mm_q, mm_d;
    time_field_t ss_q, ss_d;
    logic        is_zero_q, is_zero_d;
    logic        is_one_q, is_one_d;

    // load_zero wins over dec, dec wins over the setting increments
    always_comb begin
        mm_d = mm_q;
        ss_d = ss_q;
        if (load_zero) begin
            mm_d = '0;
            ss_d = '0;
        end else if (dec) begin
            if (ss_q != '0) begin
                ss_d = ss_q - FIELD_W'(1);
            end else if (mm_q != '0) begin
                mm_d = mm_q - FIELD_W'(1);
                ss_d = FIELD_W'(SEC_MAX);
            end
        end else begin
            if (inc_min) begin
                mm_d = wrap_inc(mm_q, FIELD_W'(MAX_MIN));
            end
            if (inc_sec) begin
                ss_d = wrap_inc(ss_q, FIELD_W'(SEC_MAX));
            end
        end
        // flags are registered alongside the value so they always match it
        is_zero_d = (mm_d == '0) && (ss_d == '0);
        is_one_d  = (mm_d == '0) && (ss_d == FIELD_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mm_q      <= '0;
            ss_q      <= '0;
            is_zero_q <= 1'b1;
            is_one_q  <= 1'b0;
        end else begin
            mm_q      <= mm_d;
            ss_q      <= ss_d;
            is_zero_q <= is_zero_d;
            is_one_q  <= is_one_d;
        end
    end

    assign mm      = mm_q;
    assign ss      = ss_q;
    assign is_zero = is_zero_q;
    assign is_one  = is_one_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Set/run/pause/alarm sequencer for the mm:ss countdown timer.
// CDC_ALARM_TIMEOUT_EN adds an alarm auto-clear after ALARM_SECS ticks.
module countdown_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned MAX_MIN = 59
`ifdef CDC_ALARM_TIMEOUT_EN
    ,
    parameter int unsigned ALARM_SECS = 10
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               btn_start,
    input  logic               btn_clear,
    input  logic               btn_inc_min,
    input  logic               btn_inc_sec,
    output logic [FIELD_W-1:0] mm,
    output logic [FIELD_W-1:0] ss,
    output logic               running,
    output logic               alarm,
    output logic [STATE_W-1:0] state_o
);

    cd_state_t state_q, state_d;
    logic      running_q, running_d;
    logic      alarm_q, alarm_d;

    logic load_zero;
    logic inc_min;
    logic inc_sec;
    logic dec;
    logic is_zero;
    logic is_one;

`ifdef CDC_ALARM_TIMEOUT_EN
    time_field_t alarm_cnt_q, alarm_cnt_d;
`endif

    mmss_counter #(
        .MAX_MIN (MAX_MIN)
    ) u_mmss (
        .clk       (clk),
        .rst       (rst),
        .load_zero (load_zero),
        .inc_min   (inc_min),
        .inc_sec   (inc_sec),
        .dec       (dec),
        .mm        (mm),
        .ss        (ss),
        .is_zero   (is_zero),
        .is_one    (is_one)
    );

    // Next state and counter controls; priority clear > start > tick > inc
    always_comb begin
        state_d   = state_q;
        load_zero = 1'b0;
        inc_min   = 1'b0;
        inc_sec   = 1'b0;
        dec       = 1'b0;
`ifdef CDC_ALARM_TIMEOUT_EN
        alarm_cnt_d = alarm_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_clear) begin
                    load_zero = 1'b1;
                end else if (btn_start) begin
                    if (!is_zero) begin
                        state_d = RUN;
                    end
                end else begin
                    inc_min = btn_inc_min;
                    inc_sec = btn_inc_sec;
                end
            end
            RUN: begin
                if (btn_clear) begin
                    state_d   = IDLE;
                    load_zero = 1'b1;
                end else if (btn_start) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    dec = 1'b1;
                    // the 00:01 -> 00:00 step lands directly in ALARM
                    if (is_one) begin
                        state_d = ALARM;
`ifdef CDC_ALARM_TIMEOUT_EN
                        alarm_cnt_d = '0;
`endif
                    end
                end
            end
            PAUSE: begin
                if (btn_clear) begin
                    state_d   = IDLE;
                    load_zero = 1'b1;
                end else if (btn_start) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                if (btn_clear || btn_start) begin
                    state_d   = IDLE;
                    load_zero = 1'b1;
                end
`ifdef CDC_ALARM_TIMEOUT_EN
                else if (tick) begin
                    if ((alarm_cnt_q + FIELD_W'(1)) >= FIELD_W'(ALARM_SECS)) begin
                        state_d   = IDLE;
                        load_zero = 1'b1;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + FIELD_W'(1);
                    end
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                load_zero = 1'b1;
            end
        endcase

        running_d = (state_d == RUN);
        alarm_d   = (state_d == ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

`ifdef CDC_ALARM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_cnt_q <= '0;
        end else begin
            alarm_cnt_q <= alarm_cnt_d;
        end
    end
`endif

    assign running = running_q;
    assign alarm   = alarm_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed scoreboard bench for countdown_ctrl; honours CDC_ALARM_TIMEOUT_EN (ALARM_SECS=3).
module tb_countdown_ctrl;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_inc_min;
    logic       btn_inc_sec;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       running;
    logic       alarm;
    logic [1:0] state_o;

    exp_t sb_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    countdown_ctrl #(
        .MAX_MIN (59)
`ifdef CDC_ALARM_TIMEOUT_EN
        ,
        .ALARM_SECS (3)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn_start   (btn_start),
        .btn_clear   (btn_clear),
        .btn_inc_min (btn_inc_min),
        .btn_inc_sec (btn_inc_sec),
        .mm          (mm),
        .ss          (ss),
        .running     (running),
        .alarm       (alarm),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

    task automatic check_out();
        exp_t        e;
        logic [15:0] obs;
        obs = {mm, ss, state_o, running, alarm};
        total_cnt++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h, expected an entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.v) pass_cnt++;
            else $error("FAIL %s: observed mm=%0d ss=%0d st=%0d run=%0b al=%0b, expected mm=%0d ss=%0d st=%0d run=%0b al=%0b",
                        e.tag, obs[15:10], obs[9:4], obs[3:2], obs[1], obs[0],
                        e.v[15:10], e.v[9:4], e.v[3:2], e.v[1], e.v[0]);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input logic r, input logic st, input logic cl, input logic im,
                        input logic is, input logic tk, input string tag,
                        input int emm, input int ess, input int est, input int erun, input int eal);
        exp_t e;
        rst = r; btn_start = st; btn_clear = cl; btn_inc_min = im; btn_inc_sec = is; tick = tk;
        e.tag = tag;
        e.v   = {6'(emm), 6'(ess), 2'(est), 1'(erun), 1'(eal)};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
        btn_inc_min = 1'b0; btn_inc_sec = 1'b0; tick = 1'b0;
        check_out();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
        btn_inc_min = 1'b0; btn_inc_sec = 1'b0;
        @(posedge clk);
        #1;
        //   rst st cl im is tk  tag                mm ss st run al
        step(1, 0, 0, 0, 0, 0, "reset",            0, 0, 0, 0, 0);

        // basic countdown into ALARM
        for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, 1, 0, "inc_sec", 0, i, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, "start_run",        0, 3, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, "tick_2",           0, 2, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, "tick_1",           0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, "tick_alarm",       0, 0, 3, 0, 1);
        step(0, 0, 0, 1, 1, 0, "alarm_ign_inc",    0, 0, 3, 0, 1);
`ifdef CDC_ALARM_TIMEOUT_EN
        step(0, 0, 0, 0, 0, 1, "alarm_to_1",       0, 0, 3, 0, 1);
        step(0, 0, 0, 0, 0, 1, "alarm_to_2",       0, 0, 3, 0, 1);
        step(0, 0, 0, 0, 0, 1, "alarm_to_3",       0, 0, 0, 0, 0);
`else
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1, "alarm_hold", 0, 0, 3, 0, 1);
        step(0, 0, 1, 0, 0, 0, "alarm_clear",      0, 0, 0, 0, 0);
`endif

        // minute borrow and pause freeze
        step(0, 0, 0, 1, 0, 0, "preset_0100",      1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, "start_0100",       1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, "borrow_0059",      0, 59, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0, "pause",            0, 59, 2, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, "pause_frozen", 0, 59, 2, 0, 0);
        step(0, 1, 0, 0, 0, 0, "resume",           0, 59, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, "tick_0058",        0, 58, 1, 1, 0);
        step(0, 0, 1, 0, 0, 0, "run_clear",        0, 0, 0, 0, 0);

        // IDLE wrap behaviour
        for (int i = 1; i <= 60; i++) step(0, 0, 0, 1, 0, 0, "min_wrap", i % 60, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, "preset_min1",      1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, "preset_min2",      2, 0, 0, 0, 0);
        for (int i = 1; i <= 60; i++) step(0, 0, 0, 0, 1, 0, "sec_wrap", 2, i % 60, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, "idle_clear",       0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, "start_at_zero",    0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, "both_inc",         1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, "idle_ign_tick",    1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, "idle_clear2",      0, 0, 0, 0, 0);

        // same-cycle priority in RUN
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 1, 0, "preset_0005", 0, i, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, "start_0005",       0, 5, 1, 1, 0);
        step(0, 1, 0, 0, 0, 1, "start_beats_tick", 0, 5, 2, 0, 0);
        step(0, 1, 0, 0, 0, 0, "resume_0005",      0, 5, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0, "clear_beats_start",0, 0, 0, 0, 0);

        // reset from ALARM and from RUN
        step(0, 0, 0, 0, 1, 0, "preset_0001",      0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, "start_0001",       0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, "alarm_again",      0, 0, 3, 0, 1);
        step(1, 0, 0, 0, 0, 0, "rst_in_alarm",     0, 0, 0, 0, 0);
        for (int i = 1; i <= 30; i++) step(0, 0, 0, 0, 1, 0, "preset_0030", 0, i, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, "start_0030",       0, 30, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0, "run_ign_inc",      0, 30, 1, 1, 0);
        step(1, 1, 0, 0, 0, 1, "rst_in_run",       0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencing controller for the timer's mm:ss datapath.
- Owns the MM:SS value and runs the set, run, pause and alarm sequence, advancing only on the one-cycle 1 Hz `tick` strobe.
- Sits between the debounced front-panel button pulses and the display/alarm drivers.
- Replaces free-running minute counting with a user-controlled countdown.

Parameters:
- MAX_MIN, 59, highest minute value; minute increment wraps MAX_MIN -> 0.
- ALARM_SECS, 10, ticks the alarm stays asserted before auto-clear (used only with CDC_ALARM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  1 Hz enable, one clk cycle wide.
- btn_start  in  1  start/pause toggle pulse, one cycle.
- btn_clear  in  1  clear/abort pulse, one cycle.
- btn_inc_min  in  1  minute increment pulse.
- btn_inc_sec  in  1  second increment pulse.
- mm  out  6  minutes remaining, 0..MAX_MIN.
- ss  out  6  seconds remaining, 0..59.
- running  out  1  high in RUN.
- alarm  out  1  high in ALARM.
- state_o  out  2  encoded state, for debug.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Registered outputs: all outputs are registered and reflect an input event on the next posedge (1-cycle latency).
- Reset values: mm=0, ss=0, state=IDLE, running=0, alarm=0.
- Reset mid-RUN or mid-ALARM: returns to the reset values on the next edge.
- Event priority per cycle: rst > btn_clear > btn_start > tick > inc buttons. A lower-priority event in the same cycle is dropped, not deferred.
- States are IDLE, RUN, PAUSE and ALARM (encoded 0..3).
- IDLE:
  - btn_inc_min: mm = (mm==MAX_MIN) ? 0 : mm+1.
  - btn_inc_sec: ss = (ss==59) ? 0 : ss+1, with no carry into mm.
  - Both inc buttons in one cycle: both apply.
  - btn_start with mm:ss != 00:00 -> RUN.
  - btn_start at 00:00 is ignored and the state stays IDLE.
  - btn_clear -> mm=ss=0.
  - tick is ignored.
- RUN:
  - On tick with ss>0: ss-1.
  - On tick with ss==0 and mm>0: mm-1, ss=59.
  - On tick at 00:01: ss=0 and state -> ALARM on the same edge.
  - 00:00 never persists in RUN.
  - btn_start -> PAUSE; a coincident tick is dropped.
  - btn_clear -> IDLE with 00:00.
  - Inc buttons are ignored.
- PAUSE:
  - Value is frozen and tick is ignored.
  - btn_start -> RUN.
  - btn_clear -> IDLE with 00:00.
  - Inc buttons are ignored.
- ALARM:
  - alarm=1 and mm:ss holds 00:00.
  - btn_start or btn_clear -> IDLE with alarm=0.
  - tick and inc buttons are ignored, except as described under Optional Feature.
- Arithmetic: all arithmetic is 6-bit unsigned. No value may ever exceed MAX_MIN or 59.
- Button widths: pulses wider than one cycle are not supported; each high cycle counts as one event.

Optional Feature:
- Macro: CDC_ALARM_TIMEOUT_EN.
- Defined:
  - A 6-bit alarm tick counter clears on ALARM entry and increments on each tick while in ALARM.
  - When the counter reaches ALARM_SECS, the state returns to IDLE and alarm=0 on that edge.
  - Buttons still clear the alarm early.
- Undefined:
  - The counter is absent.
  - ALARM holds indefinitely until btn_start or btn_clear.

Decomposition:
- Package `timer_pkg`:
  - typedef enum logic [1:0] cd_state_t {IDLE, RUN, PAUSE, ALARM}.
  - localparam SEC_MAX = 59.
  - 6-bit typedef time_field_t.
- Sub-module `mmss_counter`:
  - Holds mm/ss.
  - Inputs: load_zero, inc_min, inc_sec, dec.
  - Outputs: mm, ss, is_zero, is_one (value == 00:01).
  - Contains all wrap and borrow logic.
- `countdown_ctrl`: the FSM, button priority and the optional alarm timer.

Test Plan:
- Reset, then 3x btn_inc_sec -> 00:03. btn_start -> running=1 next cycle. Three ticks -> 00:02, 00:01, then 00:00 with alarm=1 and state_o=3 on the third tick edge.
- Preset 01:00, start, one tick -> 00:59. btn_start -> PAUSE. Five ticks -> stays 00:59. btn_start, one tick -> 00:58.
- Wrap checks in IDLE:
  - MAX_MIN+1 presses of btn_inc_min -> mm=0.
  - 60 presses of btn_inc_sec -> ss=0 with mm unchanged.
  - btn_start at 00:00 -> state stays IDLE.
- Preset 00:05, RUN:
  - btn_start and tick in the same cycle -> PAUSE with value 00:05.
  - btn_clear and btn_start in the same cycle -> IDLE, 00:00.
- Reset asserted in ALARM -> next edge mm=ss=0, alarm=0, IDLE. In RUN at 00:30, rst -> 00:00, IDLE.
- ALARM timeout:
  - With CDC_ALARM_TIMEOUT_EN and ALARM_SECS=3: reach ALARM, 3 ticks -> alarm=0, IDLE on the third.
  - Without the macro: 20 ticks -> alarm still 1; btn_clear -> IDLE.
